frac_seq_divider: RTL and testbench
===================================

Name: frac_seq_divider

Overview:
- Parametrised multi-cycle restoring shift-and-subtract divider. Computes Q = floor(numer * 2^FRAC_W / denom), with optional round-half-up.
- Used wherever the datapath needs a fixed-point ratio (e.g. interpolation weights), so one DSP-free unit is shared across requests.
- Adds a start/busy/done handshake, operand capture, divide-by-zero detection and a selectable rounding mode.

Parameters:
- NUM_W, 7: numerator width (unsigned).
- DEN_W, 7: denominator width (unsigned).
- FRAC_W, 8: fractional bits of the result.
- ROUND_MODE, 0: 0 = floor, 1 = round half up.
- Derived Q_W = NUM_W+FRAC_W (result width). Derived N = Q_W (iterations).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request; accepted only in IDLE or DONE.
- numer  in  NUM_W  dividend, sampled on the accepting edge.
- denom  in  DEN_W  divisor, sampled on the accepting edge.
- busy  out  1  high in RUN and ROUND.
- done  out  1  one-cycle pulse, result valid.
- quotient  out  Q_W  result in Q(NUM_W).(FRAC_W); held until the next accept.
- remainder  out  DEN_W  partial remainder after N iterations, before rounding.
- div0  out  1  denom was 0 for the current result; held with quotient.

Behaviour:
- Reset: state IDLE; busy=0, done=0, div0=0, quotient=0, remainder=0.
- Reset mid-operation aborts the operation with no done pulse.
- States: IDLE, RUN, ROUND, DONE.
- Accept on edge E0 (start=1 in IDLE or DONE):
  - Capture numer and denom.
  - Internal dividend D = {numer, FRAC_W zeros}.
  - Internal remainder register R (DEN_W+1 bits) = 0.
  - Iteration counter = N-1.
  - quotient, remainder and div0 are cleared.
  - If denom==0: go to DONE, set quotient = all ones, remainder=0, div0=1. done is high in the cycle after E0.
  - Otherwise go to RUN.
- RUN, one bit per edge, MSB first:
  - R' = {R, next D bit}.
  - If R' >= denom: R = R' - denom and shift 1 into the quotient; else R = R' and shift 0.
  - Compare and subtract are DEN_W+1 bits wide, zero-extended, with no truncation.
  - After N RUN edges (edge E0+N), go to DONE if ROUND_MODE=0, else to ROUND.
- ROUND (ROUND_MODE=1 only, one edge):
  - Compute one extra bit: 2R >= denom.
  - If that bit is 1, quotient += 1. No overflow is possible: a nonzero remainder implies the quotient is below all ones.
  - remainder output keeps its pre-round value.
  - Go to DONE.
- DONE:
  - done=1 for exactly this one cycle.
  - Next edge goes to IDLE, or to RUN/DONE if start=1 (back-to-back accept, no idle bubble).
- Latency, start edge to done high:
  - N+1 cycles with ROUND_MODE=0 (done in the cycle after E0+N).
  - N+2 cycles with ROUND_MODE=1.
  - 1 cycle for divide-by-zero.
- start while busy: ignored, no queuing; captured operands do not change.
- Changes on numer or denom after the accept edge have no effect.
- quotient is stable from done until the next accept edge, including through IDLE.

Test Plan:
- Defaults, ROUND_MODE=0, numer=1, denom=3 -> quotient=0x0055 (85), remainder=1, div0=0. done high exactly 16 cycles after the start edge, busy high for 15 cycles.
- Defaults, ROUND_MODE=1, numer=2, denom=3 -> quotient=171 (floor would give 170), remainder=2, done at 17 cycles. Also numer=1, denom=3 -> 85, no increment.
- numer=127, denom=1 -> quotient=0x7F00, remainder=0. Then numer=0, denom=5 -> quotient=0, remainder=0.
- numer=5, denom=0 -> div0=1, quotient=0x7FFF, done one cycle after start. The next valid request clears div0.
- Pulse start at cycle 5 of a running 1/3 with numer=2, denom=3 -> ignored, result still 85. Then assert start on the done cycle with 2/3 -> accepted, result 170, done 16 cycles later.
- Assert rst at iteration 8 -> next cycle busy=0, done=0, quotient=0, no done pulse. A new request afterwards completes correctly.

Source files
------------

// File: rtl/frac_seq_divider.sv
// Multi-cycle restoring divider: quotient = floor(numer * 2^FRAC_W / denom),
// with optional round-half-up, a start/busy/done handshake and divide-by-zero flag.
module frac_seq_divider #(
  parameter  int NUM_W      = 7,
  parameter  int DEN_W      = 7,
  parameter  int FRAC_W     = 8,
  parameter  int ROUND_MODE = 0,
  localparam int Q_W        = NUM_W + FRAC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] numer,
  input  logic [DEN_W-1:0] denom,
  output logic             busy,
  output logic             done,
  output logic [Q_W-1:0]   quotient,
  output logic [DEN_W-1:0] remainder,
  output logic             div0
);

  localparam int N     = Q_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, ROUND, DONE} state_t;

  state_t           state, state_nxt;
  logic [Q_W-1:0]   dividend;
  logic [DEN_W-1:0] den;
  logic [DEN_W:0]   rem_r;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic [DEN_W+1:0] r_shift;
  logic             ge;
  logic [DEN_W:0]   r_step;
  logic             round_up;

  // The partial remainder stays below den, so the subtraction fits in DEN_W+1 bits.
  always_comb begin
    accept   = start && (state == IDLE || state == DONE);
    r_shift  = {rem_r, dividend[Q_W-1]};
    ge       = (r_shift >= {2'b00, den});
    r_step   = ge ? (r_shift[DEN_W:0] - {1'b0, den}) : r_shift[DEN_W:0];
    round_up = ({rem_r, 1'b0} >= {2'b00, den});
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept)             state_nxt = (denom == '0) ? DONE : RUN;
        else if (state == DONE) state_nxt = IDLE;
      end
      RUN:     if (cnt == '0) state_nxt = (ROUND_MODE != 0) ? ROUND : DONE;
      ROUND:   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      quotient <= '0;
      rem_r    <= '0;
      div0     <= 1'b0;
    end else if (accept) begin
      quotient <= (denom == '0) ? '1 : '0;
      rem_r    <= '0;
      div0     <= (denom == '0);
    end else begin
      case (state)
        RUN: begin
          quotient <= {quotient[Q_W-2:0], ge};
          rem_r    <= r_step;
        end
        ROUND:   if (round_up) quotient <= quotient + Q_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: operand and counter registers are loaded on every accept before use,
  // so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      den      <= denom;
      dividend <= {numer, {FRAC_W{1'b0}}};
      cnt      <= CNT_W'(N - 1);
    end else if (state == RUN) begin
      dividend <= dividend << 1;
      cnt      <= cnt - 1'b1;
    end
  end

  assign busy      = (state == RUN) || (state == ROUND);
  assign done      = (state == DONE);
  assign remainder = rem_r[DEN_W-1:0];

endmodule

// File: tb/tb_frac_seq_divider.sv
// Scoreboard bench: one floor-mode and one round-mode divider share the request
// stream; an arithmetic model predicts each result and the cycle it appears.
module tb_frac_seq_divider;

  localparam int NUM_W  = 7;
  localparam int DEN_W  = 7;
  localparam int FRAC_W = 8;
  localparam int Q_W    = NUM_W + FRAC_W;
  localparam int N      = Q_W;

  typedef struct {
    int q;
    int r;
    int z;
    int cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [NUM_W-1:0] numer;
  logic [DEN_W-1:0] denom;

  logic             busy0, done0, div00;
  logic [Q_W-1:0]   quot0;
  logic [DEN_W-1:0] rem0;
  logic             busy1, done1, div01;
  logic [Q_W-1:0]   quot1;
  logic [DEN_W-1:0] rem1;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last0 = -10;
  int   last1 = -10;
  int   busy_cnt0 = 0;
  int   busy_cnt1 = 0;
  exp_t sb0[$];
  exp_t sb1[$];

  frac_seq_divider #(.NUM_W(NUM_W), .DEN_W(DEN_W), .FRAC_W(FRAC_W), .ROUND_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .numer(numer), .denom(denom),
    .busy(busy0), .done(done0), .quotient(quot0), .remainder(rem0), .div0(div00)
  );

  frac_seq_divider #(.NUM_W(NUM_W), .DEN_W(DEN_W), .FRAC_W(FRAC_W), .ROUND_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .numer(numer), .denom(denom),
    .busy(busy1), .done(done1), .quotient(quot1), .remainder(rem1), .div0(div01)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h) at cycle %0d", tag, got, got, exp, exp, cyc);
    end
  endtask

  // Independent arithmetic model; e is the accepting edge number.
  function automatic exp_t model(input int n, input int d, input bit rnd, input int e);
    exp_t x;
    if (d == 0) begin
      x.q = (1 << Q_W) - 1;
      x.r = 0;
      x.z = 1;
      x.cyc = e;
    end else begin
      x.q = (n << FRAC_W) / d;
      x.r = (n << FRAC_W) % d;
      x.z = 0;
      if (rnd && (2 * x.r >= d)) x.q = x.q + 1;
      x.cyc = e + (rnd ? N + 1 : N);
    end
    return x;
  endfunction

  // A unit accepts on edge e only once its previous done cycle has been reached.
  task automatic request(input int n, input int d);
    int   e;
    exp_t x;
    @(negedge clk);
    start = 1'b1;
    numer = NUM_W'(n);
    denom = DEN_W'(d);
    e = cyc + 1;
    if (e > last0) begin
      x = model(n, d, 1'b0, e);
      sb0.push_back(x);
      last0 = x.cyc;
    end
    if (e > last1) begin
      x = model(n, d, 1'b1, e);
      sb1.push_back(x);
      last1 = x.cyc;
    end
    @(negedge clk);
    start = 1'b0;
    numer = NUM_W'($urandom);
    denom = DEN_W'($urandom);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && (sb0.size() != 0 || sb1.size() != 0); k++) @(negedge clk);
    check("drain_unit0", sb0.size(), 0);
    check("drain_unit1", sb1.size(), 0);
  endtask

  always @(negedge clk) begin
    if (busy0) busy_cnt0++;
    if (busy1) busy_cnt1++;
  end

  always @(negedge clk) begin
    exp_t x;
    if (done0) begin
      if (sb0.size() == 0) check("unexpected_done0", 1, 0);
      else begin
        x = sb0.pop_front();
        check("quot0", int'(quot0), x.q);
        check("rem0", int'(rem0), x.r);
        check("div0_0", int'(div00), x.z);
        check("done_cyc0", cyc, x.cyc);
      end
    end
    if (done1) begin
      if (sb1.size() == 0) check("unexpected_done1", 1, 0);
      else begin
        x = sb1.pop_front();
        check("quot1", int'(quot1), x.q);
        check("rem1", int'(rem1), x.r);
        check("div0_1", int'(div01), x.z);
        check("done_cyc1", cyc, x.cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    numer = '0;
    denom = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy0 | busy1), 0);
    check("rst_done", int'(done0 | done1), 0);
    check("rst_div0", int'(div00 | div01), 0);
    check("rst_quot", int'(quot0 | quot1), 0);
    check("rst_rem", int'(rem0 | rem1), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1/3: floor 85 rem 1; round mode sees 2*1 < 3, so no increment.
    busy_cnt0 = 0;
    busy_cnt1 = 0;
    request(1, 3);
    drain();
    check("busy_len0", busy_cnt0, N);
    check("busy_len1", busy_cnt1, N + 1);

    request(2, 3);
    drain();

    request(127, 1);
    drain();
    repeat (4) @(negedge clk);
    check("hold_quot0", int'(quot0), 'h7F00);
    check("hold_quot1", int'(quot1), 'h7F00);
    request(0, 5);
    drain();

    request(5, 0);
    drain();
    repeat (3) @(negedge clk);
    check("hold_div0", int'(div00), 1);
    request(1, 3);
    drain();
    request(100, 7);
    drain();
    request(127, 127);
    drain();

    // Start pulsed while busy must be ignored; then re-accept on the done cycle.
    request(1, 3);
    repeat (3) @(negedge clk);
    request(2, 3);
    while (cyc != last0 - 1) @(negedge clk);
    request(2, 3);
    drain();

    // Reset partway through the iterations aborts without a done pulse.
    request(1, 3);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sb0.delete();
    sb1.delete();
    last0 = -10;
    last1 = -10;
    check("abort_busy", int'(busy0 | busy1), 0);
    check("abort_done", int'(done0 | done1), 0);
    check("abort_quot", int'(quot0 | quot1), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    request(2, 3);
    drain();
    request(77, 13);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
